// File: rtl/aes_package.sv
// Shared types and default configuration for the AES HWPE job controller.
package aes_package;

    localparam int DEF_BLOCK_BITS = 256;
    localparam int DEF_MAX_LEN    = 256;
    localparam int DEF_JOB_DEPTH  = 4;
    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_LEN_W      = $clog2(DEF_MAX_LEN) + 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STARTING = 3'd1,
        ST_WORKING  = 3'd2,
        ST_DRAINING = 3'd3,
        ST_FINISHED = 3'd4
    } aes_ctrl_state_t;

    // Job descriptor at the default configuration.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr_in;
        logic [DEF_ADDR_W-1:0] addr_out;
        logic [DEF_LEN_W-1:0]  len;
        logic                  mode;
    } aes_job_t;

    function automatic int job_bits(input int addr_w, input int len_w);
        return 2 * addr_w + len_w + 1;
    endfunction

endpackage

// File: rtl/aes_job_fifo.sv
// Synchronous show-ahead FIFO of job descriptors with occupancy level and flush.
module aes_job_fifo #(
    parameter int  DATA_W = 8,
    parameter int  DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int LVL_W  = PTR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic [LVL_W-1:0]  level_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic              do_push;
    logic              do_pop;

    assign do_push = push_i && (level_q != LVL_W'(DEPTH));
    assign do_pop  = pop_i && (level_q != '0);

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      level_q <= level_q + LVL_W'(1);
            else if (!do_push && do_pop) level_q <= level_q - LVL_W'(1);
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign empty_o = (level_q == '0);

endmodule

// File: rtl/aes_job_ctrl.sv
// Job-queued sequencer for the AES HWPE: queues jobs and runs the source streamer,
// engine and sink streamer for the head job, with a drain phase and error pulses.
module aes_job_ctrl
    import aes_package::*;
#(
    parameter int  BLOCK_BITS = DEF_BLOCK_BITS,
    parameter int  MAX_LEN    = DEF_MAX_LEN,
    parameter int  JOB_DEPTH  = DEF_JOB_DEPTH,
    parameter int  ADDR_W     = DEF_ADDR_W,
    parameter int  CNT_W      = DEF_CNT_W,
    localparam int LEN_W      = $clog2(MAX_LEN) + 1,
    localparam int LVL_W      = $clog2(JOB_DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              job_valid_i,
    output logic              job_ready_o,
    input  logic [ADDR_W-1:0] job_addr_in_i,
    input  logic [ADDR_W-1:0] job_addr_out_i,
    input  logic [LEN_W-1:0]  job_len_i,
    input  logic              job_mode_i,
    output logic              src_start_o,
    output logic              sink_start_o,
    output logic              eng_start_o,
    output logic [ADDR_W-1:0] src_addr_o,
    output logic [ADDR_W-1:0] sink_addr_o,
    output logic [LEN_W-1:0]  xfer_len_o,
    output logic              eng_mode_o,
    input  logic              eng_chunk_valid_i,
    input  logic              sink_idle_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  done_count_o,
    output logic [LVL_W-1:0]  queue_level_o
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr_in;
        logic [ADDR_W-1:0] addr_out;
        logic [LEN_W-1:0]  len;
        logic              mode;
    } job_t;

    localparam int JOB_W = job_bits(ADDR_W, LEN_W);

    if (JOB_DEPTH < 2 || (JOB_DEPTH & (JOB_DEPTH - 1)) != 0 || (BLOCK_BITS % 128) != 0
        || $bits(job_t) != JOB_W) begin : g_bad_params
        $error("aes_job_ctrl: unsupported parameter set");
    end

    job_t             push_job;
    job_t             head_job;
    logic [LVL_W-1:0] level;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    aes_ctrl_state_t  state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] src_addr_q, src_addr_d;
    logic [ADDR_W-1:0] sink_addr_q, sink_addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             mode_q, mode_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
    logic             ready_en_q;

    assign push_job = '{addr_in: job_addr_in_i, addr_out: job_addr_out_i,
                        len: job_len_i, mode: job_mode_i};

    // Readiness uses only the registered level, so a same-cycle pop never frees a slot.
    assign job_ready_o = ready_en_q && (level < LVL_W'(JOB_DEPTH)) && !clear_i;
    assign push        = job_valid_i && job_ready_o;

    aes_job_fifo #(
        .DATA_W (JOB_W),
        .DEPTH  (JOB_DEPTH)
    ) u_job_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (clear_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_job),
        .data_o  (head_job),
        .level_o (level),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        src_addr_d  = src_addr_q;
        sink_addr_d = sink_addr_q;
        len_d       = len_q;
        mode_d      = mode_q;
        err_d       = 1'b0;
        done_cnt_d  = done_cnt_q;
        pop         = 1'b0;
        if (clear_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        if (head_job.len == '0) begin
                            pop   = 1'b1;
                            err_d = 1'b1;
                        end else begin
                            state_d     = ST_STARTING;
                            src_addr_d  = head_job.addr_in;
                            sink_addr_d = head_job.addr_out;
                            len_d       = head_job.len;
                            mode_d      = head_job.mode;
                        end
                    end
                end
                ST_STARTING: begin
                    cnt_d   = '0;
                    state_d = ST_WORKING;
                end
                ST_WORKING: begin
                    if (eng_chunk_valid_i) begin
                        cnt_d = cnt_q + LEN_W'(1);
                        if (cnt_d == len_q) state_d = ST_DRAINING;
                    end
                end
                ST_DRAINING: begin
                    if (eng_chunk_valid_i) err_d = 1'b1;
                    if (sink_idle_i) begin
                        state_d    = ST_FINISHED;
                        done_cnt_d = done_cnt_q + CNT_W'(1);
                    end
                end
                ST_FINISHED: begin
                    pop     = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            src_addr_q  <= '0;
            sink_addr_q <= '0;
            len_q       <= '0;
            mode_q      <= 1'b0;
            err_q       <= 1'b0;
            done_cnt_q  <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            src_addr_q  <= src_addr_d;
            sink_addr_q <= sink_addr_d;
            len_q       <= len_d;
            mode_q      <= mode_d;
            err_q       <= err_d;
            done_cnt_q  <= done_cnt_d;
            ready_en_q  <= 1'b1;
        end
    end

    assign src_start_o   = (state_q == ST_STARTING);
    assign sink_start_o  = (state_q == ST_STARTING);
    assign eng_start_o   = (state_q == ST_STARTING);
    assign done_o        = (state_q == ST_FINISHED);
    assign err_o         = err_q;
    assign busy_o        = (state_q != ST_IDLE) || !fifo_empty;
    assign src_addr_o    = src_addr_q;
    assign sink_addr_o   = sink_addr_q;
    assign xfer_len_o    = len_q;
    assign eng_mode_o    = mode_q;
    assign done_count_o  = done_cnt_q;
    assign queue_level_o = level;

endmodule
